cmap_encoder: RTL and testbench

Compresses dense weight tensors into the cmap format that cmap_decoder consumes. Each dense beat yields two outputs: a per-group zero/non-zero bitmap with per-group non-zero counts, and the non-zero elements compacted and packed into a continuous stream of DIN_BYTES-wide words. It sits on the weight-preparation path, upstream of the storage/DMA that later feeds cmap_decoder.

---
 rtl/cmap_encoder.sv | 182 ++++++++++++++++++
 tb/tb_cmap_encoder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmap_encoder.sv
// cmap_encoder: turns dense weight beats into a per-group zero/non-zero
// bitmap with group popcounts, plus a packed stream of the non-zero elements
// cut into DIN_BYTES-wide words. The final word of a tensor carries enc_last
// and may be partial (or empty, as an end marker).
module cmap_encoder #(
    parameter int ZNZ_BITS  = 16,
    parameter int DATA_W    = 8,
    parameter int NUM_GROUP = 4,
    parameter int DIN_BYTES = NUM_GROUP * ZNZ_BITS
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [DIN_BYTES-1:0][DATA_W-1:0]         dense_din,
    input  logic                                     dense_vld,
    input  logic                                     dense_last,
    output logic                                     dense_rdy,
    output logic [NUM_GROUP-1:0][ZNZ_BITS-1:0]       znz_dout,
    output logic [NUM_GROUP-1:0][$clog2(ZNZ_BITS):0] nz_num,
    output logic                                     znz_vld,
    input  logic                                     znz_rdy,
    output logic [DIN_BYTES-1:0][DATA_W-1:0]         enc_dout,
    output logic [$clog2(DIN_BYTES):0]               enc_cnt,
    output logic                                     enc_last,
    output logic                                     enc_vld,
    input  logic                                     enc_rdy
);

    localparam int NW        = $clog2(ZNZ_BITS) + 1;
    localparam int CW        = $clog2(DIN_BYTES) + 1;
    localparam int ACC_LANES = 2 * DIN_BYTES;
    localparam int AW        = $clog2(ACC_LANES);
    localparam int DIN_W     = DIN_BYTES * DATA_W;
    localparam int ACC_W     = ACC_LANES * DATA_W;

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0]                          acc_cnt;
    logic [ACC_LANES-1:0][DATA_W-1:0]       acc_data;
    logic [AW-1:0]                          cnt_next;
    logic [ACC_LANES-1:0][DATA_W-1:0]       acc_next;
    logic [ACC_LANES-1:0][DATA_W-1:0]       acc_shift;
    logic [AW-1:0]                          base;

    logic [DIN_BYTES-1:0]                   nz_map;
    logic [DIN_BYTES-1:0][DATA_W-1:0]       comp;
    logic [CW-1:0]                          beat_cnt;
    logic [NUM_GROUP-1:0][NW-1:0]           grp_cnt;

    logic znz_free;
    logic accept;
    logic pop;
    logic clear;

    // Zero test per element and compaction of non-zeros in ascending lane order.
    always_comb begin
        nz_map   = '0;
        comp     = '0;
        beat_cnt = '0;
        for (int unsigned i = 0; i < DIN_BYTES; i++) begin
            nz_map[i] = |dense_din[i];
            if (nz_map[i]) begin
                comp[beat_cnt[CW-2:0]] = dense_din[i];
                beat_cnt = beat_cnt + CW'(1);
            end
        end
    end

    // Per-group popcount of the bitmap; NW bits so a full group reads ZNZ_BITS.
    always_comb begin
        grp_cnt = '0;
        for (int unsigned g = 0; g < NUM_GROUP; g++) begin
            for (int unsigned m = 0; m < ZNZ_BITS; m++) begin
                grp_cnt[g] = grp_cnt[g] + NW'(nz_map[g*ZNZ_BITS+m]);
            end
        end
    end

    assign znz_free = !znz_vld || znz_rdy;
    assign accept   = dense_vld && dense_rdy;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Next state, handshake signals and output-word framing.
    always_comb begin
        state_d   = state_q;
        dense_rdy = 1'b0;
        enc_vld   = 1'b0;
        enc_cnt   = '0;
        enc_last  = 1'b0;
        pop       = 1'b0;
        clear     = 1'b0;
        case (state_q)
            RUN: begin
                dense_rdy = !rst && znz_free &&
                            ((acc_cnt < AW'(DIN_BYTES)) || enc_rdy);
                enc_vld   = (acc_cnt >= AW'(DIN_BYTES));
                if (enc_vld) enc_cnt = CW'(DIN_BYTES);
                pop       = enc_vld && enc_rdy;
                if (dense_vld && dense_rdy && dense_last) state_d = DRAIN;
            end
            DRAIN: begin
                enc_vld = 1'b1;
                if (acc_cnt > AW'(DIN_BYTES)) begin
                    enc_cnt = CW'(DIN_BYTES);
                    pop     = enc_rdy;
                end else begin
                    enc_cnt  = CW'(acc_cnt);
                    enc_last = 1'b1;
                    if (enc_rdy) begin
                        clear   = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Lanes at or above acc_cnt are always zero, so the bottom word is
    // already zero-filled for a partial final word.
    always_comb begin
        enc_dout = '0;
        if (enc_vld) enc_dout = acc_data[DIN_BYTES-1:0];
    end

    // Accumulator update: pop first, then append the compacted beat at the
    // post-pop fill level.
    always_comb begin
        acc_shift = acc_data;
        base      = acc_cnt;
        if (pop) begin
            acc_shift = acc_data >> DIN_W;
            base      = acc_cnt - AW'(DIN_BYTES);
        end
        acc_next = acc_shift;
        cnt_next = base;
        if (accept) begin
            acc_next = acc_shift | ({{(ACC_W-DIN_W){1'b0}}, comp} << (base * DATA_W));
            cnt_next = base + AW'(beat_cnt);
        end
        if (clear) begin
            acc_next = '0;
            cnt_next = '0;
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_data <= '0;
            acc_cnt  <= '0;
        end else begin
            acc_data <= acc_next;
            acc_cnt  <= cnt_next;
        end
    end

    // One-entry bitmap/count register, held while not consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            znz_vld  <= 1'b0;
            znz_dout <= '0;
            nz_num   <= '0;
        end else if (accept) begin
            znz_vld  <= 1'b1;
            znz_dout <= nz_map;
            nz_num   <= grp_cnt;
        end else if (znz_rdy) begin
            znz_vld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmap_encoder.sv
// Scoreboard bench for cmap_encoder: the driver pushes expected bitmap and
// packed-word entries, an independent monitor pops them on each handshake.
module tb_cmap_encoder;

    typedef logic [63:0][7:0] beat_t;

    typedef struct packed {
        beat_t      data;
        logic [6:0] cnt;
        logic       last;
    } enc_exp_t;

    typedef struct packed {
        logic [63:0]     map;
        logic [3:0][4:0] nz;
    } znz_exp_t;

    logic            clk = 1'b0;
    logic            rst;
    beat_t           dense_din;
    logic            dense_vld;
    logic            dense_last;
    logic            dense_rdy;
    logic [3:0][15:0] znz_dout;
    logic [3:0][4:0] nz_num;
    logic            znz_vld;
    logic            znz_rdy;
    beat_t           enc_dout;
    logic [6:0]      enc_cnt;
    logic            enc_last;
    logic            enc_vld;
    logic            enc_rdy;

    int checks   = 0;
    int failures = 0;

    enc_exp_t   enc_q[$];
    znz_exp_t   znz_q[$];
    logic [7:0] pend[$];

    cmap_encoder #(
        .ZNZ_BITS (16),
        .DATA_W   (8),
        .NUM_GROUP(4),
        .DIN_BYTES(64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dense_din (dense_din),
        .dense_vld (dense_vld),
        .dense_last(dense_last),
        .dense_rdy (dense_rdy),
        .znz_dout  (znz_dout),
        .nz_num    (nz_num),
        .znz_vld   (znz_vld),
        .znz_rdy   (znz_rdy),
        .enc_dout  (enc_dout),
        .enc_cnt   (enc_cnt),
        .enc_last  (enc_last),
        .enc_vld   (enc_vld),
        .enc_rdy   (enc_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic emit(input int unsigned n, input logic last);
        enc_exp_t e;
        e.data = '0;
        for (int unsigned k = 0; k < n; k++) e.data[k] = pend.pop_front();
        e.cnt  = 7'(n);
        e.last = last;
        enc_q.push_back(e);
    endtask

    // Reference behaviour: bitmap/popcount per beat, non-zeros appended to a
    // byte stream, full words cut at 64 and the remainder flushed on last.
    task automatic model_push(input beat_t d, input logic last);
        znz_exp_t z;
        z.map = '0;
        z.nz  = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (d[i] != 8'h00) begin
                z.map[i]    = 1'b1;
                z.nz[i/16]  = z.nz[i/16] + 5'd1;
                pend.push_back(d[i]);
            end
        end
        znz_q.push_back(z);
        if (!last) begin
            if (pend.size() >= 64) emit(64, 1'b0);
        end else begin
            while (pend.size() > 64) emit(64, 1'b0);
            emit(pend.size(), 1'b1);
        end
    endtask

    // Presents a beat until accepted; returns 1 time unit after the accepting edge.
    task automatic send_beat(input beat_t d, input logic last);
        int unsigned n = 0;
        dense_din  = d;
        dense_last = last;
        dense_vld  = 1'b1;
        forever begin
            @(negedge clk);
            if (dense_rdy) begin
                model_push(d, last);
                break;
            end
            n++;
            if (n > 500) begin
                checks++;
                failures++;
                $display("FAIL dense_accept_timeout: got no dense_rdy required acceptance");
                break;
            end
        end
        @(posedge clk);
        #1;
        dense_vld  = 1'b0;
        dense_last = 1'b0;
        dense_din  = '0;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while ((enc_q.size() != 0 || znz_q.size() != 0) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending words required 0", enc_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every handshake against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (znz_vld && znz_rdy) begin
                znz_exp_t z;
                if (znz_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL znz_unexpected: got znz_vld=1 required no output");
                end else begin
                    z = znz_q.pop_front();
                    chk("znz_dout", znz_dout, z.map);
                    chk("nz_num", nz_num, z.nz);
                end
            end
            if (enc_vld && enc_rdy) begin
                enc_exp_t e;
                if (enc_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL enc_unexpected: got enc_vld=1 cnt=%0d required no output", enc_cnt);
                end else begin
                    e = enc_q.pop_front();
                    chk("enc_dout", enc_dout, e.data);
                    chk("enc_cnt", enc_cnt, e.cnt);
                    chk("enc_last", enc_last, e.last);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion required end of test");
        $fatal(1);
    end

    initial begin
        beat_t b;
        beat_t fill;
        rst        = 1'b1;
        dense_din  = '0;
        dense_vld  = 1'b0;
        dense_last = 1'b0;
        znz_rdy    = 1'b1;
        enc_rdy    = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rdy_in_reset", dense_rdy, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_znz_vld", znz_vld, 1'b0);
        chk("rst_enc_vld", enc_vld, 1'b0);
        chk("rst_enc_cnt", enc_cnt, 7'd0);
        chk("rst_enc_dout", enc_dout, '0);
        chk("rst_znz_dout", znz_dout, '0);
        chk("rst_nz_num", nz_num, '0);
        chk("rst_dense_rdy", dense_rdy, 1'b1);
        @(posedge clk);
        #1;

        // 1: all 0x01, not last
        for (int i = 0; i < 64; i++) b[i] = 8'h01;
        send_beat(b, 1'b0);
        chk("t1_znz_vld", znz_vld, 1'b1);
        chk("t1_znz_dout", znz_dout, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_nz_num", nz_num, {5'd16, 5'd16, 5'd16, 5'd16});
        chk("t1_enc_vld", enc_vld, 1'b1);
        chk("t1_enc_cnt", enc_cnt, 7'd64);
        chk("t1_enc_dout", enc_dout, b);

        // 2: lane i = i, then all-zero last beat
        for (int i = 0; i < 64; i++) b[i] = 8'(i);
        send_beat(b, 1'b0);
        chk("t2_znz_g0", znz_dout[0], 16'hFFFE);
        chk("t2_nz_num", nz_num, {5'd16, 5'd16, 5'd16, 5'd15});
        send_beat('0, 1'b1);
        wait_idle();

        // 3: 40 + 40 non-zeros, then empty last beat -> 64 then 16
        b = '0;
        for (int i = 0; i < 40; i++) b[i] = 8'(i + 1);
        send_beat(b, 1'b0);
        b = '0;
        for (int i = 24; i < 64; i++) b[i] = 8'(8'h80 + i);
        send_beat(b, 1'b0);
        send_beat('0, 1'b1);
        wait_idle();

        // 4: single all-zero last beat -> end marker only
        send_beat('0, 1'b1);
        chk("t4_znz_vld", znz_vld, 1'b1);
        chk("t4_znz_dout", znz_dout, '0);
        chk("t4_nz_num", nz_num, '0);
        chk("t4_enc_cnt", enc_cnt, 7'd0);
        chk("t4_enc_last", enc_last, 1'b1);
        wait_idle();
        chk("t4_back_in_run", dense_rdy, 1'b1);

        // 5a: enc_rdy held low for 10 cycles with a full word pending
        enc_rdy = 1'b0;
        for (int i = 0; i < 64; i++) fill[i] = 8'h5A;
        send_beat(fill, 1'b0);
        chk("t5_rdy_drop", dense_rdy, 1'b0);
        for (int c = 0; c < 9; c++) begin
            @(posedge clk);
            #1;
            chk("t5_enc_hold", enc_dout, fill);
        end
        chk("t5_rdy_still_low", dense_rdy, 1'b0);
        enc_rdy = 1'b1;
        for (int i = 0; i < 64; i++) b[i] = 8'hA5;
        send_beat(b, 1'b1);
        wait_idle();

        // 5b: znz_rdy held low blocks further beats
        znz_rdy = 1'b0;
        b = '0;
        for (int i = 0; i < 10; i++) b[i] = 8'h33;
        send_beat(b, 1'b0);
        chk("t5_znz_full_rdy", dense_rdy, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("t5_znz_hold", znz_dout, {48'h0, 16'h03FF});
        end
        chk("t5_znz_full_rdy2", dense_rdy, 1'b0);
        znz_rdy = 1'b1;
        b = '0;
        for (int i = 0; i < 5; i++) b[i] = 8'h44;
        send_beat(b, 1'b1);
        wait_idle();

        // 6: reset with 30 elements buffered, then a clean 5-element tensor
        b = '0;
        for (int i = 0; i < 30; i++) b[i] = 8'h77;
        send_beat(b, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rdy_in_reset", dense_rdy, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pend.delete();
        enc_q.delete();
        znz_q.delete();
        chk("t6_enc_vld", enc_vld, 1'b0);
        chk("t6_znz_vld", znz_vld, 1'b0);
        chk("t6_enc_cnt", enc_cnt, 7'd0);
        b = '0;
        for (int i = 10; i < 15; i++) b[i] = 8'h09;
        send_beat(b, 1'b1);
        chk("t6_enc_cnt5", enc_cnt, 7'd5);
        chk("t6_enc_last", enc_last, 1'b1);
        wait_idle();

        chk("end_enc_q_empty", 32'(enc_q.size()), 32'd0);
        chk("end_znz_q_empty", 32'(znz_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
